scramble_sequencer: RTL

- Downstream consumer of the index scrambler's six permuted slot indices (index1..index6).
- On start, latches the permutation and plays the active slots out one at a time on a display bus, with fixed dwell and gap times.
- Then collects player guesses, scores each against the latched sequence, and reports the round result.
- Active slot count follows the same mode encoding that drives the scrambler.

---
 rtl/scramble_sequencer_if.sv | 39 +++
 rtl/scramble_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/scramble_sequencer_if.sv
// Bus bundle for scramble_sequencer: round control, scrambled indices, guesses, display and result outputs.
interface scramble_sequencer_if;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned MODE_W  = 2;
    localparam int unsigned SCORE_W = 3;

    logic               start;
    logic [MODE_W-1:0]  mode;
    logic [IDX_W-1:0]   index1;
    logic [IDX_W-1:0]   index2;
    logic [IDX_W-1:0]   index3;
    logic [IDX_W-1:0]   index4;
    logic [IDX_W-1:0]   index5;
    logic [IDX_W-1:0]   index6;
    logic [IDX_W-1:0]   guess;
    logic               guess_valid;
    logic [IDX_W-1:0]   disp_index;
    logic               disp_valid;
    logic               busy;
    logic               guess_ready;
    logic               correct_pulse;
    logic               wrong_pulse;
    logic               timeout_pulse;
    logic [SCORE_W-1:0] score;
    logic               done;
    logic               pass;

    modport master (
        output start, mode, index1, index2, index3, index4, index5, index6, guess, guess_valid,
        input  disp_index, disp_valid, busy, guess_ready, correct_pulse, wrong_pulse,
               timeout_pulse, score, done, pass
    );

    modport slave (
        input  start, mode, index1, index2, index3, index4, index5, index6, guess, guess_valid,
        output disp_index, disp_valid, busy, guess_ready, correct_pulse, wrong_pulse,
               timeout_pulse, score, done, pass
    );
endinterface

// File: rtl/scramble_sequencer.sv
// Latches a scrambled slot permutation, plays it on the display bus, then scores player guesses.
// Optional guess timeout: define SCRAMBLE_SEQ_GUESS_TIMEOUT_EN.
module scramble_sequencer #(
    parameter int unsigned DWELL_CYCLES   = 4,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned CNT_W          = 26,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic                  clk,
    input logic                  rst,
    scramble_sequencer_if.slave  bus
);
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned SLOT_W  = 3;
    localparam int unsigned SEQ_LEN = 6;

    localparam logic [CNT_W-1:0] DWELL_LAST   = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHOW,
        S_GAP,
        S_GUESS,
        S_DONE
    } state_e;

    state_e                          state_q, state_d;
    logic [SLOT_W-1:0]               slot_q, slot_d;
    logic [SLOT_W-1:0]               n_q, n_d;
    logic [CNT_W-1:0]                timer_q, timer_d;
    logic [SEQ_LEN-1:0][IDX_W-1:0]   seq_q, seq_d;
    logic [SLOT_W-1:0]               score_q, score_d;
    logic                            pass_q, pass_d;
    logic [IDX_W-1:0]                disp_index_q, disp_index_d;
    logic                            disp_valid_q, disp_valid_d;
    logic                            busy_q, busy_d;
    logic                            guess_ready_q, guess_ready_d;
    logic                            correct_pulse_q, correct_pulse_d;
    logic                            wrong_pulse_q, wrong_pulse_d;
    logic                            timeout_pulse_q, timeout_pulse_d;
    logic                            done_q, done_d;
    logic                            advance;

    // Round sequencing; outputs are derived from the next state so they land registered.
    always_comb begin
        state_d         = state_q;
        slot_d          = slot_q;
        n_d             = n_q;
        timer_d         = timer_q;
        seq_d           = seq_q;
        score_d         = score_q;
        pass_d          = pass_q;
        correct_pulse_d = 1'b0;
        wrong_pulse_d   = 1'b0;
        timeout_pulse_d = 1'b0;
        advance         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.mode != 2'b11)) begin
                    seq_d   = {bus.index6, bus.index5, bus.index4, bus.index3, bus.index2, bus.index1};
                    n_d     = SLOT_W'(4) + SLOT_W'(bus.mode);
                    slot_d  = '0;
                    timer_d = '0;
                    score_d = '0;
                    pass_d  = 1'b0;
                    state_d = S_SHOW;
                end
            end
            S_SHOW: begin
                if (timer_q == DWELL_LAST) begin
                    timer_d = '0;
                    if (slot_q == n_q - SLOT_W'(1)) begin
                        slot_d  = '0;
                        state_d = S_GUESS;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    slot_d  = slot_q + SLOT_W'(1);
                    state_d = S_SHOW;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            S_GUESS: begin
                if (bus.guess_valid) begin
                    timer_d = '0;
                    advance = 1'b1;
                    if (bus.guess == seq_q[slot_q]) begin
                        correct_pulse_d = 1'b1;
                        score_d         = score_q + SLOT_W'(1);
                    end else begin
                        wrong_pulse_d = 1'b1;
                    end
                end else if (timer_q == TIMEOUT_LAST) begin
`ifdef SCRAMBLE_SEQ_GUESS_TIMEOUT_EN
                    timer_d         = '0;
                    advance         = 1'b1;
                    wrong_pulse_d   = 1'b1;
                    timeout_pulse_d = 1'b1;
`else
                    // Timer saturates: the block waits for a guess indefinitely.
                    timer_d = timer_q;
`endif
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
                if (advance) begin
                    if (slot_q == n_q - SLOT_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        disp_valid_d  = (state_d == S_SHOW);
        disp_index_d  = disp_valid_d ? seq_d[slot_d] : '0;
        busy_d        = (state_d == S_SHOW) || (state_d == S_GAP) || (state_d == S_GUESS);
        guess_ready_d = (state_d == S_GUESS);
        done_d        = (state_d == S_DONE);
        if (state_d == S_DONE) begin
            pass_d = (score_d == n_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            slot_q          <= '0;
            n_q             <= '0;
            timer_q         <= '0;
            seq_q           <= '0;
            score_q         <= '0;
            pass_q          <= 1'b0;
            disp_index_q    <= '0;
            disp_valid_q    <= 1'b0;
            busy_q          <= 1'b0;
            guess_ready_q   <= 1'b0;
            correct_pulse_q <= 1'b0;
            wrong_pulse_q   <= 1'b0;
            timeout_pulse_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            slot_q          <= slot_d;
            n_q             <= n_d;
            timer_q         <= timer_d;
            seq_q           <= seq_d;
            score_q         <= score_d;
            pass_q          <= pass_d;
            disp_index_q    <= disp_index_d;
            disp_valid_q    <= disp_valid_d;
            busy_q          <= busy_d;
            guess_ready_q   <= guess_ready_d;
            correct_pulse_q <= correct_pulse_d;
            wrong_pulse_q   <= wrong_pulse_d;
            timeout_pulse_q <= timeout_pulse_d;
            done_q          <= done_d;
        end
    end

    assign bus.disp_index    = disp_index_q;
    assign bus.disp_valid    = disp_valid_q;
    assign bus.busy          = busy_q;
    assign bus.guess_ready   = guess_ready_q;
    assign bus.correct_pulse = correct_pulse_q;
    assign bus.wrong_pulse   = wrong_pulse_q;
    assign bus.timeout_pulse = timeout_pulse_q;
    assign bus.score         = score_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
endmodule
